nrs_cinit_seq_tx: RTL
=====================

NRS_CINIT_SEQ_TX -- requirements
Module: nrs_cinit_seq_tx

Interface
REQ-001 clk  input  1  sole clock, rising-edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 start  input  1  one-cycle frame strobe; accepted only in IDLE.
REQ-004 n_cell_id  input  9  NB-IoT cell ID, 0..503; latched on accepted start.
REQ-005 sfn_even  input  1  1 = even radio frame; latched on accepted start.
REQ-006 cinit_ready  input  1  downstream Gold-sequence generator can accept a c_init.
REQ-007 cinit_valid  output  1  c_init holds a valid seed.
REQ-008 c_init  output  31  NRS Gold seed for current (slot, symbol).
REQ-009 slot  output  5  slot index ns of current seed, 0..19.
REQ-010 sym_l  output  3  OFDM symbol index of current seed, 5 or 6.
REQ-011 first_run  output  1  high while offered seed is the frame's first.
REQ-012 last_run  output  1  high while offered seed is the frame's last.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse after last seed transfers.

Function
REQ-015 States SHALL be IDLE, CALC, OFFER; IDLE->CALC on start, CALC->OFFER after one cycle, OFFER->CALC on transfer of a non-last seed, OFFER->IDLE on transfer of the last seed.
REQ-016 A transfer SHALL occur on any cycle with cinit_valid=1 and cinit_ready=1.
REQ-017 cinit_valid SHALL be 1 exactly in OFFER; c_init, slot, sym_l, first_run, last_run SHALL stay stable while cinit_valid=1 and cinit_ready=0.
REQ-018 Latency: cinit_valid SHALL first assert 2 cycles after accepted start; after each non-last transfer, cinit_valid SHALL be low for exactly one cycle (CALC) before the next seed.
REQ-019 Run order SHALL be (ns,l) = (0,5),(0,6),(1,5),(1,6),... ascending ns, l=5 before l=6.
REQ-020 Slots 10 and 11 (NPSS subframe 5) SHALL always be skipped: after (9,6) the next seed is (12,5).
REQ-021 c_init SHALL equal 1024*(7*(ns+1)+l+1)*(2*n_cell_id+1) + 2*n_cell_id + 1, computed with an unsigned product of at least 31 bits, no truncation (max 151582703 at ns=19, l=6, ID 503).
REQ-022 first_run SHALL be 1 only for (0,5); last_run SHALL be 1 only for the final seed of the frame per REQ-020/REQ-030.
REQ-023 start SHALL be ignored while busy=1; n_cell_id/sfn_even changes during busy SHALL NOT affect the frame in progress.
REQ-024 n_cell_id > 503 SHALL be used unmodified (no clamping); behaviour is undefined for the air interface only.
REQ-025 done SHALL pulse in the cycle the state returns to IDLE; start in that same cycle SHALL be ignored (IDLE reached next edge).

Reset
REQ-026 On rst: state IDLE, cinit_valid=0, c_init=0, slot=0, sym_l=5, first_run=0, last_run=0, busy=0, done=0, latched ID=0, latched sfn_even=0.
REQ-027 rst asserted mid-frame SHALL abort immediately; no seed or done pulse SHALL follow until a new start after rst deasserts.

Configuration
REQ-028 Macro NSSS_SKIP_EN SHALL control NSSS subframe handling.
REQ-029 Without NSSS_SKIP_EN: every frame yields 36 seeds, last seed (19,6); sfn_even is latched but unused.
REQ-030 With NSSS_SKIP_EN: when latched sfn_even=1, slots 18 and 19 SHALL also be skipped, giving 32 seeds with last seed (17,6); odd frames unchanged (36 seeds).

Verification
REQ-031 rst, start with ID=0, cinit_ready=1 -> seeds 13313 (0,5), 14337 (0,6), 20481 (1,5); first valid 2 cycles after start, one-cycle valid gap between seeds.
REQ-032 ID=0, run full frame -> after (9,6) seed 99329 at (12,5); last seed 150529 at (19,6) with last_run=1; done pulse; 36 transfers total.
REQ-033 ID=1 -> first seed 39939; ID=503 -> last seed 151582703; hold cinit_ready=0 for 5 cycles mid-frame -> c_init/slot/sym_l unchanged throughout.
REQ-034 Second start pulsed at seed 3 and ID changed to 7 -> frame continues with ID 0 values, seed count unchanged.
REQ-035 rst pulsed at seed 20 -> all outputs at reset values next cycle, no done; new start -> seed 13313 again.
REQ-036 NSSS_SKIP_EN defined, sfn_even=1, ID=0 -> last seed (17,6) = 1024*133+1 = 136193, 32 transfers; sfn_even=0 -> 36 transfers.

Source files
------------

// File: rtl/nrs_cinit_seq_tx.sv
// nrs_cinit_seq_tx: sequences NB-IoT NRS Gold-sequence seeds (c_init) for
// every NRS-bearing (slot, symbol) of a radio frame over a valid/ready link.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               one-cycle frame strobe, taken only in IDLE
//   n_cell_id[8:0]      cell ID, latched on accepted start
//   sfn_even            even radio frame flag, latched on accepted start
//   cinit_ready         downstream can take a seed
//   cinit_valid         seed offered (OFFER state)
//   c_init[30:0]        seed for (slot, sym_l)
//   slot[4:0], sym_l[2:0] slot index ns and OFDM symbol (5 or 6) of the seed
//   first_run/last_run  offered seed is first / last of the frame
//   busy                not IDLE
//   done                one-cycle pulse after the last seed transfers
//
// Build option: define NSSS_SKIP_EN to also skip slots 18/19 (NSSS
// subframe 9) on even frames, ending the frame at (17,6).

module nrs_cinit_seq_tx (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [8:0]  n_cell_id,
    input  logic        sfn_even,
    input  logic        cinit_ready,
    output logic        cinit_valid,
    output logic [30:0] c_init,
    output logic [4:0]  slot,
    output logic [2:0]  sym_l,
    output logic        first_run,
    output logic        last_run,
    output logic        busy,
    output logic        done
);

`ifdef NSSS_SKIP_EN
    localparam bit SKIP_NSSS = 1'b1;
`else
    localparam bit SKIP_NSSS = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        OFFER = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [8:0]  id_q;
    logic        sfn_q;
    logic [4:0]  ns_q;
    logic        l_q;      // 0: symbol 5, 1: symbol 6
    logic [4:0]  last_ns;
    logic        is_last;
    logic        accept;
    logic        xfer;
    logic [30:0] term;
    logic [30:0] mult;
    logic [30:0] seed_nxt;

    // 7*(ns+1) + l + 1 with l = 5 + l_q  ->  7*ns + 13 + l_q
    assign term     = 31'(ns_q) * 31'd7 + 31'd13 + 31'(l_q);
    assign mult     = {21'd0, id_q, 1'b1};
    assign seed_nxt = term * mult * 31'd1024 + mult;

    assign last_ns = (SKIP_NSSS && sfn_q) ? 5'd17 : 5'd19;
    assign is_last = l_q && (ns_q == last_ns);

    // start in the done cycle is ignored: the frame is still closing out
    assign accept = (state == IDLE) && start && !done;
    assign xfer   = (state == OFFER) && cinit_ready;

    assign slot  = ns_q;
    assign sym_l = l_q ? 3'd6 : 3'd5;

    always_comb begin
        state_nxt   = state;
        cinit_valid = 1'b0;
        busy        = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (accept) state_nxt = CALC;
            end
            CALC: begin
                state_nxt = OFFER;
            end
            OFFER: begin
                cinit_valid = 1'b1;
                if (cinit_ready) state_nxt = is_last ? IDLE : CALC;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        first_run = cinit_valid && (ns_q == 5'd0) && !l_q;
        last_run  = cinit_valid && is_last;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            done   <= 1'b0;
            id_q   <= 9'd0;
            sfn_q  <= 1'b0;
            ns_q   <= 5'd0;
            l_q    <= 1'b0;
            c_init <= 31'd0;
        end else begin
            state <= state_nxt;
            done  <= xfer && is_last;
            if (accept) begin
                id_q  <= n_cell_id;
                sfn_q <= sfn_even;
                ns_q  <= 5'd0;
                l_q   <= 1'b0;
            end
            if (state == CALC) c_init <= seed_nxt;
            if (xfer && !is_last) begin
                if (l_q) begin
                    l_q  <= 1'b0;
                    // slots 10/11 carry NPSS: never NRS
                    ns_q <= (ns_q == 5'd9) ? 5'd12 : ns_q + 5'd1;
                end else begin
                    l_q <= 1'b1;
                end
            end
        end
    end

endmodule
